serial_compare_ctrl: RTL and testbench

Sequencer that compares two WIDTH-bit unsigned operands bit-serially, MSB first, through a single 1-bit comparator slice. It exits as soon as the first differing bit is found. A start/done handshake lets a requester issue one comparison at a time. The block is intended for area-constrained paths where a full-width parallel magnitude comparator is not justified.

---
 rtl/cmp_pkg.sv | 15 +
 rtl/compare_bit_slice.sv | 16 +
 rtl/serial_compare_ctrl.sv | 120 ++++++++++++
 tb/tb_serial_compare_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
// Holds the FSM state encoding and the default operand width.
// No logic; imported by the controller.
package cmp_pkg;

  localparam int CMP_WIDTH_DEFAULT = 8;

  // 2'd3 is unused and steers back to ST_IDLE in the controller
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/compare_bit_slice.sv
// 1-bit magnitude comparator slice producing one-hot gt/lt/eq.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle on whatever bit is presented.
module compare_bit_slice (
  input  logic i_a,
  input  logic i_b,
  output logic o_gt,
  output logic o_lt,
  output logic o_eq
);

  assign o_gt = i_a & ~i_b;
  assign o_lt = ~i_a & i_b;
  assign o_eq = ~(i_a ^ i_b);

endmodule

// File: rtl/serial_compare_ctrl.sv
// Bit-serial unsigned compare of two WIDTH-bit operands, MSB first, early exit.
// Latency: done 2 cycles after accept when MSB differs, WIDTH+1 when equal.
// Backpressure: start is only sampled in IDLE; requests in RUN/DONE are dropped.
module serial_compare_ctrl
  import cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_a_gt_b,
  output logic             o_a_lt_b,
  output logic             o_a_eq_b
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic             r_gt;
  logic             r_lt;
  logic             r_eq;

  logic             w_load;
  logic             w_dec;
  logic             w_finish;
  logic             w_slice_gt;
  logic             w_slice_lt;
  logic             w_slice_eq;

  compare_bit_slice u_slice (
    .i_a  (r_a[r_idx]),
    .i_b  (r_b[r_idx]),
    .o_gt (w_slice_gt),
    .o_lt (w_slice_lt),
    .o_eq (w_slice_eq)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode; busy/done come straight from state, no input paths
  always_comb begin
    w_next_state = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_load       = 1'b1;
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        o_busy = 1'b1;
        // Exit at idx==0 wins over the decrement so idx never wraps
        if (!w_slice_eq || (r_idx == '0)) begin
          w_finish     = 1'b1;
          w_next_state = ST_DONE;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_DONE: begin
        o_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Operand capture, bit index walk and result flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= '0;
      r_gt  <= 1'b0;
      r_lt  <= 1'b0;
      r_eq  <= 1'b0;
    end else begin
      if (w_load) begin
        r_a   <= i_a;
        r_b   <= i_b;
        r_idx <= IW'(WIDTH - 1);
        r_gt  <= 1'b0;
        r_lt  <= 1'b0;
        r_eq  <= 1'b0;
      end
      if (w_dec) begin
        r_idx <= r_idx - IW'(1);
      end
      // Slice outputs are one-hot, so exactly one flag gets set here
      if (w_finish) begin
        r_gt <= w_slice_gt;
        r_lt <= w_slice_lt;
        r_eq <= w_slice_eq;
      end
    end
  end

  assign o_a_gt_b = r_gt;
  assign o_a_lt_b = r_lt;
  assign o_a_eq_b = r_eq;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl at WIDTH=8.
// Inputs change and outputs are sampled on the falling edge of each cycle.
// Observed vector is {busy, done, a_gt_b, a_lt_b, a_eq_b}.
module tb_serial_compare_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       a_gt_b;
  logic       a_lt_b;
  logic       a_eq_b;

  int total;
  int bad;

  serial_compare_ctrl #(.WIDTH(8)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_a      (a),
    .i_b      (b),
    .o_busy   (busy),
    .o_done   (done),
    .o_a_gt_b (a_gt_b),
    .o_a_lt_b (a_lt_b),
    .o_a_eq_b (a_eq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {busy, done, a_gt_b, a_lt_b, a_eq_b};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s busy/done/gt/lt/eq observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    cyc();
    cyc();
    chk("reset", 5'b00000);
    rst = 1'b0;
    cyc();
    chk("idle_after_reset", 5'b00000);

    // Equal operands: full 8-bit walk, done in cycle 9
    start = 1'b1; a = 8'hA5; b = 8'hA5;
    chk("eq_c0", 5'b00000);
    cyc(); start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("eq_run_c%0d", c), 5'b10000);
      cyc();
    end
    chk("eq_done_c9", 5'b01001);
    cyc();
    chk("eq_hold_c10", 5'b00001);

    // MSB differs: fastest case
    start = 1'b1; a = 8'h80; b = 8'h7F;
    cyc(); start = 1'b0;
    chk("msb_run_c1", 5'b10000);
    cyc();
    chk("msb_done_c2", 5'b01100);
    cyc();
    chk("msb_idle_c3", 5'b00100);

    // Differ only in bit 0: A < B, flags hold afterwards
    start = 1'b1; a = 8'h12; b = 8'h13;
    chk("lsb_c0_old_flags", 5'b00100);
    cyc(); start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("lsb_run_c%0d", c), 5'b10000);
      cyc();
    end
    chk("lsb_done_c9", 5'b01010);
    for (int c = 10; c <= 14; c++) begin
      cyc();
      chk($sformatf("lsb_hold_c%0d", c), 5'b00010);
    end
    cyc();

    // Start re-asserted during RUN with new operands must be ignored
    start = 1'b1; a = 8'h40; b = 8'h00;
    cyc();
    a = 8'h00; b = 8'hFF;
    chk("ign_run_c1", 5'b10000);
    cyc(); start = 1'b0;
    chk("ign_run_c2", 5'b10000);
    cyc();
    chk("ign_done_c3", 5'b01100);
    cyc();
    chk("ign_idle_c4", 5'b00100);
    cyc();

    // Reset mid-RUN aborts, then a fresh comparison runs normally
    start = 1'b1; a = 8'h01; b = 8'h01;
    cyc(); start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("abort_run_c%0d", c), 5'b10000);
      if (c == 4) rst = 1'b1;
      cyc();
    end
    rst = 1'b0;
    chk("abort_c5", 5'b00000);
    cyc();
    start = 1'b1; a = 8'h03; b = 8'h02;
    chk("abort_c6_no_done", 5'b00000);
    cyc(); start = 1'b0;
    for (int c = 7; c <= 14; c++) begin
      chk($sformatf("restart_run_c%0d", c), 5'b10000);
      cyc();
    end
    chk("restart_done_c15", 5'b01100);
    cyc();
    chk("restart_idle_c16", 5'b00100);
    cyc();

    // Start held high: back-to-back accepts, done in cycles 2, 5, 8
    start = 1'b1; a = 8'hF0; b = 8'h0F;
    cyc();
    chk("hold_run_c1", 5'b10000);
    cyc();
    chk("hold_done_c2", 5'b01100);
    cyc();
    chk("hold_idle_c3", 5'b00100);
    cyc();
    chk("hold_run_c4_cleared", 5'b10000);
    cyc();
    chk("hold_done_c5", 5'b01100);
    cyc();
    chk("hold_idle_c6", 5'b00100);
    cyc();
    chk("hold_run_c7", 5'b10000);
    cyc();
    chk("hold_done_c8", 5'b01100);
    start = 1'b0;
    cyc();
    chk("hold_idle_c9", 5'b00100);
    cyc();
    chk("hold_idle_c10", 5'b00100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
